// File: rtl/seg_scan_ctrl.sv
// +--------------------------------------------------------------------------+
// | seg_scan_ctrl: 4-digit seven-segment scan controller sharing one decoder |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg_scan_ctrl #(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [15:0] value_i,
  input  logic        load_i,
  input  logic [3:0]  dp_mask_i,
  input  logic        lz_blank_i,
  output logic [3:0]  hex_sel_o,
  input  logic [7:0]  dec_seg_i,
  output logic [7:0]  seg_o,
  output logic [3:0]  an_o,
  output logic        frame_done_o
);

  localparam int CW = $clog2(PRESCALE);

  localparam logic [CW-1:0] c_CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] c_BLANK_LAST = CW'(BLANK_CYC - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_BLANK = 2'd1;
  localparam logic [1:0] c_ST_DRIVE = 2'd2;

  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          fd_q, fd_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic w_apply;
  logic w_suppress;
  logic w_lit;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    fd_d     = 1'b0;
    w_apply  = (st_q == c_ST_IDLE);

    if (!enable_i) begin
      st_d  = c_ST_IDLE;
      cnt_d = '0;
      dig_d = 2'd0;
    end else begin
      case (st_q)
        c_ST_IDLE: begin
          st_d  = c_ST_BLANK;
          cnt_d = '0;
          dig_d = 2'd0;
        end
        c_ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == c_BLANK_LAST) begin
            st_d = c_ST_DRIVE;
          end
        end
        c_ST_DRIVE: begin
          if (cnt_q == c_CNT_LAST) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
            st_d  = c_ST_BLANK;
            // Wrapping out of digit 3 is the only frame boundary where a new value may land.
            if (dig_q == 2'd3) begin
              fd_d    = 1'b1;
              w_apply = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          st_d  = c_ST_IDLE;
          cnt_d = '0;
          dig_d = 2'd0;
        end
      endcase
    end

    if (w_apply && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end
    if (load_i) begin
      pend_d   = value_i;
      pend_v_d = 1'b1;
    end
  end

  always_comb begin
    w_suppress = 1'b0;
    if (lz_blank_i) begin
      case (dig_q)
        2'd1:    w_suppress = (disp_q[15:4]  == 12'd0);
        2'd2:    w_suppress = (disp_q[15:8]  == 8'd0);
        2'd3:    w_suppress = (disp_q[15:12] == 4'd0);
        default: w_suppress = 1'b0;
      endcase
    end
  end

  // Pins are registered from the next state so they light exactly during DRIVE cycles.
  always_comb begin
    w_lit = (st_d == c_ST_DRIVE) && !w_suppress;
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (w_lit) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = {dec_seg_i[7] & ~dp_mask_i[dig_q], dec_seg_i[6:0]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q     <= c_ST_IDLE;
      cnt_q    <= '0;
      dig_q    <= 2'd0;
      disp_q   <= 16'd0;
      pend_q   <= 16'd0;
      pend_v_q <= 1'b0;
      fd_q     <= 1'b0;
      seg_q    <= 8'hFF;
      an_q     <= 4'hF;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      fd_q     <= fd_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign hex_sel_o    = disp_q[{dig_q, 2'b00} +: 4];
  assign seg_o        = seg_q;
  assign an_o         = an_q;
  assign frame_done_o = fd_q;

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display that shares one hex-to-segment decoder among all four digits. It holds a 16-bit display value and steps through the digits, presenting one nibble at a time to the decoder on `hex_sel` and driving the matching anode. It registers the decoder's `dec_seg` result onto the pins. It sits between the design's value source (counters, switch logic) and the board's segment/anode pins, and adds blank-time anti-ghosting, tear-free value updates, per-digit decimal points and optional leading-zero suppression.

## Interface
- `PRESCALE`, default 50000: clock cycles per digit slot, blank time included; legal range is BLANK_CYC+1 and up.
- `BLANK_CYC`, default 16: cycles per slot with all anodes off; must be ≥1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `enable`  in  1  1 = scanning; 0 = display dark (IDLE).
- `value`  in  16  display value; nibble k is shown on digit k; digit 0 is the rightmost.
- `load`  in  1  single-cycle strobe that captures `value` into the pending register.
- `dp_mask`  in  4  bit k = 1 lights the decimal point of digit k.
- `lz_blank`  in  1  1 = suppress leading zeros.
- `hex_sel`  out  4  nibble presented to the shared decoder.
- `dec_seg`  in  8  decoder output, active-low, bit 7 = dp (combinational from `hex_sel`).
- `seg`  out  8  registered segment pins, active-low, bit 7 = dp.
- `an`  out  4  registered anode enables, active-low.
- `frame_done`  out  1  one-cycle pulse at the end of digit 3's slot.

## Operation
- **Registers**
  - `pend` (16b) and `pend_v` (1b) hold a captured value until it is applied.
  - `disp` (16b) is the value being shown.
  - `d` (2b) is the current digit index.
  - `cnt` counts cycles within a slot and is `$clog2(PRESCALE)` bits wide.
- **load**
  - `load` writes `pend <= value` and sets `pend_v`. A later `load` before application overwrites `pend`; the last one wins.
  - `pend` is applied (`disp <= pend`, `pend_v` cleared) only on the BLANK entry with d = 0. This is a frame boundary, so a frame never mixes old and new nibbles.
  - In IDLE, `pend` is applied on the next cycle.
  - If `load` arrives in the same cycle as the application, the new `value` goes into `pend`, `pend_v` stays set, and the old `pend` is applied.
- **States**
  - **IDLE**
    - Drives `an` = 4'b1111, `seg` = 8'hFF, `cnt` = 0, `d` = 0.
    - `enable` = 1 moves to BLANK.
  - **BLANK**
    - Drives `an` = 4'b1111, `seg` = 8'hFF, `hex_sel` = `disp[4d+3:4d]`.
    - When `cnt` = BLANK_CYC−1, moves to DRIVE; `cnt` keeps counting.
  - **DRIVE**
    - Drives `an[d]` = 0 and the other anodes 1.
    - Drives `seg` = `dec_seg` with bit 7 forced to 0 when `dp_mask[d]` = 1.
    - When `cnt` = PRESCALE−1: `cnt` <= 0, `d` <= d+1 (3 wraps to 0), return to BLANK. When d = 3, also pulse `frame_done`.
- **enable low**: `enable` = 0 in any state moves to IDLE on the next edge and aborts the current slot. The next enable restarts at digit 0.
- **Leading-zero suppression**
  - Digit d > 0 is suppressed when `lz_blank` = 1 and `disp[15:4d]` = 0. Suppression is evaluated using `disp` during DRIVE.
  - A suppressed digit keeps `an` = 4'b1111 and `seg` = 8'hFF for its whole slot; its dp is also suppressed.
  - Slot timing is unchanged by suppression.
  - Digit 0 is never suppressed, so 0x0000 shows "0".
- **Outputs**: `hex_sel` is combinational from `d` and `disp`; `seg` and `an` are registered.

## Timing
- **Reset values**
  - `an` = 4'b1111, `seg` = 8'hFF, `frame_done` = 0, `hex_sel` = 0.
  - `disp` = 0, `pend` = 0, `pend_v` = 0, `d` = 0, `cnt` = 0, state = IDLE.
- **Reset mid-slot** blanks the outputs immediately (asynchronous). The first slot after release starts at digit 0.
- **Slot length**: PRESCALE cycles. The first BLANK_CYC cycles are dark and the remaining PRESCALE−BLANK_CYC cycles drive the digit. A frame is 4·PRESCALE cycles.
- **Anode/segment alignment**: `an` and `seg` change on the same edge. `hex_sel` is stable for at least BLANK_CYC cycles before the digit lights.
- **IDLE→BLANK**: the first `enable` = 1 cycle is sampled, and BLANK begins on the following edge with `cnt` = 0.
- **frame_done** is asserted in the cycle after the last DRIVE cycle of digit 3. This coincides with BLANK of digit 0 and with the `pend` application.
- **load→visible latency**: at most one frame plus BLANK_CYC+1 cycles.

## Test plan
1. **Reset state.** Assert `rst` mid-DRIVE → `an` = 1111 and `seg` = FF within the same cycle. After release and `enable` = 1, digit 0 is the first digit lit.
2. **Scan sequence.** With PRESCALE=8, BLANK_CYC=2, `value` = 0x1234 loaded, `enable` = 1 →
   - anodes go 1110, 1101, 1011, 0111, each active for 6 cycles after 2 dark cycles;
   - `hex_sel` = 4, 3, 2, 1;
   - `frame_done` pulses every 32 cycles.
3. **Tear-free update.** Load 0xAAAA, then load 0x5555 during digit 2's slot → digits 2 and 3 still show A in that frame. The next frame shows all 5s, starting from the `frame_done` cycle.
4. **Leading zeros.** `lz_blank` = 1 with `value` = 0x0070 → digits 3 and 2 dark, digit 1 shows 7 and digit 0 shows 0. `value` = 0x0000 → only digit 0 lit.
5. **Decimal point.** `dp_mask` = 4'b0100 with `value` = 0x8888 → `seg` = 8'h00 on digit 2 and 8'h80 on the other digits.
6. **Disable.** Drop `enable` mid-slot → dark on the next edge. Re-enable → restarts at digit 0, and a `load` made while IDLE is displayed in the first frame.
